// File: rtl/regwrite_scoreboard_decoder_if.sv
// Bundle between decode/issue, writeback and the regwrite scoreboard decoder.
// master = pipeline side driving requests, slave = decoder/scoreboard.
interface regwrite_scoreboard_decoder_if #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
);
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_addr;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_addr;
  logic                flush;
  logic [ADDR_W-1:0]   rs1_addr;
  logic [ADDR_W-1:0]   rs2_addr;
  logic [NUM_REGS-1:0] wr_onehot;
  logic                rs1_busy;
  logic                rs2_busy;
  logic [NUM_REGS-1:0] pending;
  logic [ADDR_W:0]     pending_cnt;

  modport master (
    output wb_en, wb_addr, issue_en, issue_addr, flush, rs1_addr, rs2_addr,
    input  wr_onehot, rs1_busy, rs2_busy, pending, pending_cnt
  );

  modport slave (
    input  wb_en, wb_addr, issue_en, issue_addr, flush, rs1_addr, rs2_addr,
    output wr_onehot, rs1_busy, rs2_busy, pending, pending_cnt
  );
endinterface

// File: rtl/regwrite_scoreboard_decoder.sv
// Registered one-hot write-enable decoder plus per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN: a same-cycle writeback masks the source-busy flags.
module regwrite_scoreboard_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int ZERO_REG = 31
) (
  input logic clk,
  input logic reset,
  regwrite_scoreboard_decoder_if.slave bus
);

  logic [NUM_REGS-1:0] wr_onehot_reg;
  logic [NUM_REGS-1:0] wr_onehot_next;
  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [ADDR_W:0]     pending_cnt_reg;
  logic [ADDR_W:0]     pending_cnt_next;

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] rs1_sel;
  logic [NUM_REGS-1:0] rs2_sel;

  // Address matches are built per register, so out-of-range addresses match nothing.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam bit IS_ZERO = (gi == ZERO_REG);
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

    assign set_vec[gi] = bus.issue_en && (bus.issue_addr == IDX) && !IS_ZERO;
    assign clr_vec[gi] = bus.wb_en && (bus.wb_addr == IDX);
    assign wr_onehot_next[gi] = clr_vec[gi] && !IS_ZERO;
    assign rs1_sel[gi] = (bus.rs1_addr == IDX) && !IS_ZERO;
    assign rs2_sel[gi] = (bus.rs2_addr == IDX) && !IS_ZERO;

    // Set beats clear: the newly issued producer is still outstanding.
    assign pending_next[gi] = bus.flush ? set_vec[gi]
                                        : (set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]));
  end

  always_comb begin
    pending_cnt_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_cnt_next = pending_cnt_next + (ADDR_W + 1)'(pending_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_onehot_reg   <= '0;
      pending_reg     <= '0;
      pending_cnt_reg <= '0;
    end else begin
      wr_onehot_reg   <= wr_onehot_next;
      pending_reg     <= pending_next;
      pending_cnt_reg <= pending_cnt_next;
    end
  end

  logic rs1_wb_hit;
  logic rs2_wb_hit;

`ifdef WB_BYPASS_EN
  // Register file writes before it reads, so a same-cycle writeback is already visible.
  assign rs1_wb_hit = bus.wb_en && (bus.wb_addr == bus.rs1_addr);
  assign rs2_wb_hit = bus.wb_en && (bus.wb_addr == bus.rs2_addr);
`else
  assign rs1_wb_hit = 1'b0;
  assign rs2_wb_hit = 1'b0;
`endif

  assign bus.rs1_busy    = (|(pending_reg & rs1_sel)) && !rs1_wb_hit;
  assign bus.rs2_busy    = (|(pending_reg & rs2_sel)) && !rs2_wb_hit;
  assign bus.wr_onehot   = wr_onehot_reg;
  assign bus.pending     = pending_reg;
  assign bus.pending_cnt = pending_cnt_reg;

endmodule

// File: tb/tb_regwrite_scoreboard_decoder.sv
// Directed self-checking bench for regwrite_scoreboard_decoder.
module tb_regwrite_scoreboard_decoder;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regwrite_scoreboard_decoder_if #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

  regwrite_scoreboard_decoder #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.wb_en = 1'b0; bus.wb_addr = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    bus.flush = 1'b0;
  endtask

  // Advance one edge; inputs are driven, outputs sampled, 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t wr_onehot=%h pending=%h cnt=%0d", $time, bus.wr_onehot, bus.pending, bus.pending_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    #1;
    checks++;
    if (bus.wr_onehot !== 32'h0) begin failures++; $display("FAIL reset_wr: got %h want %h", bus.wr_onehot, 32'h0); end
    checks++;
    if (bus.pending !== 32'h0 || bus.pending_cnt !== 6'd0) begin
      failures++; $display("FAIL reset_pending: got %h/%0d want 0/0", bus.pending, bus.pending_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_decode();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd8;
    tick();
    checks++;
    if (bus.wr_onehot !== 32'h0000_0100) begin failures++; $display("FAIL decode_8: got %h want %h", bus.wr_onehot, 32'h0000_0100); end
    bus.wb_en = 1'b0; bus.wb_addr = 5'd4;
    tick();
    checks++;
    if (bus.wr_onehot !== 32'h0) begin failures++; $display("FAIL decode_off: got %h want %h", bus.wr_onehot, 32'h0); end
  endtask

  task automatic test_back_to_back();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1;
    tick();
    checks++;
    if (bus.wr_onehot !== 32'h0000_0002) begin failures++; $display("FAIL b2b_1: got %h want %h", bus.wr_onehot, 32'h2); end
    bus.wb_addr = 5'd30;
    tick();
    checks++;
    if (bus.wr_onehot !== 32'h4000_0000) begin failures++; $display("FAIL b2b_30: got %h want %h", bus.wr_onehot, 32'h4000_0000); end
    idle();
    tick();
  endtask

  task automatic test_zero_reg();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd31;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd31;
    bus.rs1_addr = 5'd31;
    tick();
    checks++;
    if (bus.wr_onehot !== 32'h0) begin failures++; $display("FAIL zero_wr: got %h want %h", bus.wr_onehot, 32'h0); end
    checks++;
    if (bus.pending !== 32'h0 || bus.pending_cnt !== 6'd0) begin
      failures++; $display("FAIL zero_pending: got %h/%0d want 0/0", bus.pending, bus.pending_cnt);
    end
    checks++;
    if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b want 0", bus.rs1_busy); end
    idle();
  endtask

  task automatic test_scoreboard();
    bus.issue_en = 1'b1;
    bus.issue_addr = 5'd3; tick();
    bus.issue_addr = 5'd5; tick();
    bus.issue_addr = 5'd9; tick();
    idle();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    #1;
    checks++;
    if (bus.pending !== 32'h0000_0228 || bus.pending_cnt !== 6'd3) begin
      failures++; $display("FAIL sb_issue: got %h/%0d want 00000228/3", bus.pending, bus.pending_cnt);
    end
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin
      failures++; $display("FAIL sb_busy: got %b%b want 10", bus.rs1_busy, bus.rs2_busy);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending_cnt !== 6'd2 || bus.rs1_busy !== 1'b0 || bus.pending !== 32'h0000_0208) begin
      failures++; $display("FAIL sb_wb: got %h/%0d busy=%b want 00000208/2 busy=0", bus.pending, bus.pending_cnt, bus.rs1_busy);
    end
  endtask

  task automatic test_set_clr_same();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7;
    tick();
    checks++;
    if (bus.pending !== 32'h0000_0288 || bus.pending_cnt !== 6'd3) begin
      failures++; $display("FAIL setclr_same: got %h/%0d want 00000288/3", bus.pending, bus.pending_cnt);
    end
    bus.issue_en = 1'b0;
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_0208 || bus.pending_cnt !== 6'd2) begin
      failures++; $display("FAIL clr_alone: got %h/%0d want 00000208/2", bus.pending, bus.pending_cnt);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7;
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_0208) begin failures++; $display("FAIL clr_idle: got %h want 00000208", bus.pending); end
  endtask

  task automatic test_flush();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd5;
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_0228) begin failures++; $display("FAIL flush_pre: got %h want 00000228", bus.pending); end
    bus.flush = 1'b1; bus.issue_en = 1'b1; bus.issue_addr = 5'd12;
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_1000 || bus.pending_cnt !== 6'd1) begin
      failures++; $display("FAIL flush_issue: got %h/%0d want 00001000/1", bus.pending, bus.pending_cnt);
    end
  endtask

  task automatic test_bypass();
    logic exp_busy;
`ifdef WB_BYPASS_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    bus.issue_en = 1'b1; bus.issue_addr = 5'd10;
    tick();
    idle();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd10;
    bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd12;
    #1;
    checks++;
    if (bus.rs1_busy !== exp_busy) begin failures++; $display("FAIL bypass_rs1: got %b want %b", bus.rs1_busy, exp_busy); end
    checks++;
    if (bus.rs2_busy !== 1'b1) begin failures++; $display("FAIL bypass_rs2: got %b want 1", bus.rs2_busy); end
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_1000 || bus.rs1_busy !== 1'b0) begin
      failures++; $display("FAIL bypass_after: got %h busy=%b want 00001000 busy=0", bus.pending, bus.rs1_busy);
    end
  endtask

  task automatic test_async_reset();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd20;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd8;
    bus.rs1_addr = 5'd12;
    tick();
    checks++;
    if (bus.pending !== 32'h0010_1000 || bus.wr_onehot !== 32'h0000_0100) begin
      failures++; $display("FAIL areset_pre: got %h/%h want 00101000/00000100", bus.pending, bus.wr_onehot);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.wr_onehot !== 32'h0 || bus.pending !== 32'h0 || bus.pending_cnt !== 6'd0 || bus.rs1_busy !== 1'b0) begin
      failures++; $display("FAIL areset_now: got %h/%h/%0d/%b want 0/0/0/0", bus.wr_onehot, bus.pending, bus.pending_cnt, bus.rs1_busy);
    end
    #1;
    reset = 1'b1;
    bus.issue_addr = 5'd4;
    tick();
    idle();
    checks++;
    if (bus.wr_onehot !== 32'h0000_0100 || bus.pending !== 32'h0000_0010 || bus.pending_cnt !== 6'd1) begin
      failures++; $display("FAIL areset_post: got %h/%h/%0d want 00000100/00000010/1", bus.wr_onehot, bus.pending, bus.pending_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_zero_reg();
    test_scoreboard();
    test_set_clr_same();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regwrite_scoreboard_decoder.md
Name: regwrite_scoreboard_decoder

Overview:
- Parametrised successor to the register-file write-enable decoder.
- Decodes a writeback address into a registered one-hot write-enable bus, with a ZERO_REG write suppressed.
- Keeps a per-register pending-write scoreboard: set when an instruction that writes a register issues, cleared at writeback.
- Sits between decode/issue and the register file. The hazard unit reads two source-busy flags from it.

Parameters:
ADDR_W, 5, register address width
NUM_REGS, 2**ADDR_W, number of registers / width of one-hot bus
ZERO_REG, 31, hard-wired zero register index (XZR); writes to it never decode or pend

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wb_en  input  1  writeback RegWrite
wb_addr  input  ADDR_W  writeback destination register
issue_en  input  1  issuing instruction writes a register
issue_addr  input  ADDR_W  issuing instruction destination
flush  input  1  pipeline flush; clears the scoreboard
rs1_addr  input  ADDR_W  source 1 lookup address
rs2_addr  input  ADDR_W  source 2 lookup address
wr_onehot  output  NUM_REGS  registered write enables; bit i is register i
rs1_busy  output  1  source 1 has a pending write
rs2_busy  output  1  source 2 has a pending write
pending  output  NUM_REGS  scoreboard vector
pending_cnt  output  ADDR_W+1  population count of pending

Behaviour:
- Reset (reset=0, asynchronous): wr_onehot=0, pending=0, pending_cnt=0. The busy outputs are therefore 0.
- Decode path:
  - At the clock edge, wr_onehot <= one-hot(wb_addr) if wb_en=1 and wb_addr!=ZERO_REG; otherwise all zeros.
  - Latency is 1 cycle. At most one bit of wr_onehot is set.
  - Out-of-range wb_addr (>=NUM_REGS when NUM_REGS < 2**ADDR_W) decodes to all zeros.
- Scoreboard, per bit i, evaluated at each clock edge:
  - set_i = issue_en and issue_addr==i and i!=ZERO_REG.
  - clr_i = wb_en and wb_addr==i.
  - If flush=1: pending <= 0, unless set_i is asserted the same cycle, in which case that bit is set. An instruction issuing during flush is the new, surviving producer.
  - Otherwise pending_i <= set_i | (pending_i & ~clr_i). Set wins over a simultaneous clear to the same register, because the newer producer is outstanding.
  - A clear with pending_i=0 has no effect.
  - Setting an already-pending bit leaves it at 1. There is no multi-producer counting.
- pending_cnt is registered and always equals popcount(pending) as of the same edge. It is computed from the next-state vector, never incremented or decremented. Range 0..NUM_REGS-1 because ZERO_REG is excluded.
- rs1_busy/rs2_busy are combinational from the pending register: pending[rsN_addr]. A lookup of ZERO_REG always gives 0. An out-of-range lookup gives 0.
- Issue and lookup of the same register in the same cycle: busy reflects the old pending value. Issue takes effect next cycle.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion acts on inputs normally.

Optional Feature:
WB_BYPASS_EN
- Defined: rsN_busy = pending[rsN_addr] & ~(wb_en & wb_addr==rsN_addr). A register whose writeback occurs this cycle reports not busy, matching the register file's write-before-read forwarding.
- Undefined: rsN_busy = pending[rsN_addr] only; that register reads busy until the next edge.
- The decode path and the pending/pending_cnt registers are identical in both builds.

Test Plan:
- Reset then wb_en=1, wb_addr=8 -> next cycle wr_onehot=32'h0000_0100. wb_en=0 with addr=4 -> next cycle wr_onehot=0.
- wb_en=1, wb_addr=31 (ZERO_REG); issue_en=1, issue_addr=31 -> wr_onehot=0, pending[31]=0, pending_cnt unchanged, rs1_busy=0 with rs1_addr=31.
- Issue regs 3, 5, 9 on consecutive cycles -> pending=32'h0000_0228, pending_cnt=3. rs1_addr=5 gives busy=1, rs2_addr=6 gives busy=0. Then wb reg 5 -> next cycle pending_cnt=2, rs1_busy=0.
- Same cycle issue_addr=7 and wb_addr=7 with pending[7]=1 -> pending[7] stays 1. wb_addr=7 alone on the next cycle -> pending[7]=0.
- pending=32'h0000_0228, flush=1 with issue_en=1, issue_addr=12 -> next cycle pending=32'h0000_1000, pending_cnt=1.
- pending[10]=1, wb_en=1, wb_addr=10, rs1_addr=10 in the same cycle -> rs1_busy=0 with WB_BYPASS_EN, 1 without. Reset pulsed low mid-stream -> all outputs 0 immediately, without waiting for an edge.
